// File: rtl/uart_pkg.sv
// Shared UART constants: bit timing, frame shape and the receiver state encoding.
// The transmitter takes its reload value from here so both ends agree on the baud.
package uart_pkg;

    localparam int BIT_PERIOD  = 10417;
    localparam int HALF_PERIOD = BIT_PERIOD / 2;
    localparam int CNT_W       = 16;
    localparam int TX_RELOAD   = BIT_PERIOD - 1;

    localparam int DATA_BITS   = 8;
    localparam int STOP_BITS   = 1;

    typedef logic [CNT_W-1:0]     count_t;
    typedef logic [DATA_BITS-1:0] byte_t;
    typedef logic [1:0]           rx_state_t;

    localparam rx_state_t RX_IDLE  = 2'd0;
    localparam rx_state_t RX_START = 2'd1;
    localparam rx_state_t RX_DATA  = 2'd2;
    localparam rx_state_t RX_STOP  = 2'd3;

    // Reload values are always one less than the interval because a tick fires on zero.
    function automatic count_t reload_for(input int interval);
        return count_t'(interval - 1);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous input, with a selectable reset level
// so idle-high lines do not produce a false edge when reset is released.
module uart_sync2 #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic arst_n,
    input  logic clear,
    input  logic line,
    output logic synced
);

    logic meta;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            meta   <= RESET_VALUE;
            synced <= RESET_VALUE;
        end else if (clear) begin
            meta   <= RESET_VALUE;
            synced <= RESET_VALUE;
        end else begin
            meta   <= line;
            synced <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: mid-bit sampling driven by a down-counter, one-cycle
// valid/frame_err strobes, no backpressure.
module uart_rx #(
    parameter int BIT_PERIOD  = uart_pkg::BIT_PERIOD,
    parameter int HALF_PERIOD = BIT_PERIOD / 2
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       rst,
    input  logic       RX,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    import uart_pkg::*;

    localparam count_t BIT_RELOAD  = reload_for(BIT_PERIOD);
    localparam count_t HALF_RELOAD = reload_for(HALF_PERIOD);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic      rx_s;
    logic      rx_prev;
    rx_state_t state;
    count_t    cnt;
    logic [2:0] bit_cnt;
    byte_t     shift;
    logic      tick;
    logic      start_edge;

    uart_sync2 #(
        .RESET_VALUE(1'b1)
    ) u_sync (
        .clk    (clk),
        .arst_n (arst_n),
        .clear  (rst),
        .line   (RX),
        .synced (rx_s)
    );

    assign tick       = (state != RX_IDLE) && (cnt == '0);
    assign start_edge = !rx_s && rx_prev;
    assign busy       = (state != RX_IDLE);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rx_prev <= 1'b1;
        end else if (rst) begin
            rx_prev <= 1'b1;
        end else begin
            rx_prev <= rx_s;
        end
    end

    // The first reload is half a bit so every later tick lands mid-bit.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt <= '0;
        end else if (rst) begin
            cnt <= '0;
        end else if (state == RX_IDLE) begin
            if (start_edge) begin
                cnt <= HALF_RELOAD;
            end
        end else if (tick) begin
            cnt <= BIT_RELOAD;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= RX_IDLE;
        end else if (rst) begin
            state <= RX_IDLE;
        end else begin
            case (state)
                RX_IDLE: begin
                    if (start_edge) begin
                        state <= RX_START;
                    end
                end
                RX_START: begin
                    if (tick) begin
                        state <= rx_s ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (tick && bit_cnt == LAST_BIT) begin
                        state <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (tick) begin
                        state <= RX_IDLE;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            bit_cnt <= '0;
            shift   <= '0;
        end else if (rst) begin
            bit_cnt <= '0;
            shift   <= '0;
        end else if (state == RX_START && tick) begin
            bit_cnt <= '0;
        end else if (state == RX_DATA && tick) begin
            shift   <= {rx_s, shift[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // A bad stop bit leaves the previously delivered byte untouched.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else if (rst) begin
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            if (state == RX_STOP && tick) begin
                if (rx_s) begin
                    data  <= shift;
                    valid <= 1'b1;
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a shortened bit period; pulse and busy-edge
// timestamps are logged on the falling clock edge and compared to hand-derived edges.
module tb_uart_rx;

    localparam int BIT          = 16;
    localparam int HALF         = BIT / 2;
    localparam int START_SAMPLE = 2 + HALF;
    localparam int STOP_SAMPLE  = 2 + HALF + 9 * BIT;

    logic       clk    = 1'b0;
    logic       arst_n = 1'b0;
    logic       rst    = 1'b0;
    logic       RX     = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;
    int edge_cnt    = 0;
    logic busy_q    = 1'b0;

    int         valid_edges[$];
    logic [7:0] valid_data[$];
    int         ferr_edges[$];
    int         rise_edges[$];
    int         fall_edges[$];

    uart_rx #(
        .BIT_PERIOD  (BIT),
        .HALF_PERIOD (HALF)
    ) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .rst       (rst),
        .RX        (RX),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // After posedge k the falling edge sees edge_cnt == k, so logged values are edge indices.
    always @(negedge clk) begin
        if (valid) begin
            valid_edges.push_back(edge_cnt);
            valid_data.push_back(data);
        end
        if (frame_err) ferr_edges.push_back(edge_cnt);
        if (busy && !busy_q) rise_edges.push_back(edge_cnt);
        if (!busy && busy_q) fall_edges.push_back(edge_cnt);
        busy_q = busy;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clearLog();
        valid_edges.delete();
        valid_data.delete();
        ferr_edges.delete();
        rise_edges.delete();
        fall_edges.delete();
    endtask

    task automatic driveBit(input logic b);
        RX = b;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] value, input logic stop_bit, output int start_edge);
        start_edge = edge_cnt + 1;
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) driveBit(value[i]);
        driveBit(stop_bit);
    endtask

    initial begin
        int e0;
        int e1;
        logic [7:0] aborted;

        aborted = 8'hC3;
        repeat (3) @(negedge clk);
        checkOutput("reset_data", data, 8'h00);
        checkOutput("reset_valid", valid, 1'b0);
        checkOutput("reset_frame_err", frame_err, 1'b0);
        checkOutput("reset_busy", busy, 1'b0);
        arst_n = 1'b1;
        repeat (2 * BIT) @(negedge clk);

        // Loopback of a single byte.
        clearLog();
        applyStimulus(8'hA5, 1'b1, e0);
        repeat (BIT) @(negedge clk);
        checkOutput("a5_valid_count", valid_edges.size(), 1);
        checkOutput("a5_valid_edge", (valid_edges.size() > 0) ? valid_edges[0] : -1, e0 + STOP_SAMPLE);
        checkOutput("a5_data", data, 8'hA5);
        checkOutput("a5_ferr_count", ferr_edges.size(), 0);
        checkOutput("a5_busy_rise", (rise_edges.size() > 0) ? rise_edges[0] : -1, e0 + 2);
        checkOutput("a5_busy_fall", (fall_edges.size() > 0) ? fall_edges[0] : -1, e0 + STOP_SAMPLE);
        checkOutput("a5_busy_after", busy, 1'b0);

        // Back-to-back frames with no idle gap.
        clearLog();
        applyStimulus(8'h00, 1'b1, e0);
        applyStimulus(8'hFF, 1'b1, e1);
        repeat (BIT) @(negedge clk);
        checkOutput("b2b_valid_count", valid_edges.size(), 2);
        checkOutput("b2b_first_edge", (valid_edges.size() > 0) ? valid_edges[0] : -1, e0 + STOP_SAMPLE);
        checkOutput("b2b_gap", (valid_edges.size() > 1) ? valid_edges[1] - valid_edges[0] : -1, 10 * BIT);
        checkOutput("b2b_data0", (valid_data.size() > 0) ? valid_data[0] : 8'hEE, 8'h00);
        checkOutput("b2b_data1", (valid_data.size() > 1) ? valid_data[1] : 8'hEE, 8'hFF);

        // Glitch shorter than half a bit must be rejected at the start sample.
        clearLog();
        e0 = edge_cnt + 1;
        RX = 1'b0;
        repeat (4) @(negedge clk);
        RX = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        checkOutput("fs_busy_rise", (rise_edges.size() > 0) ? rise_edges[0] : -1, e0 + 2);
        checkOutput("fs_busy_fall", (fall_edges.size() > 0) ? fall_edges[0] : -1, e0 + START_SAMPLE);
        checkOutput("fs_valid_count", valid_edges.size(), 0);
        checkOutput("fs_ferr_count", ferr_edges.size(), 0);
        checkOutput("fs_busy", busy, 1'b0);

        // Low stop bit, then the line stays low as a break.
        clearLog();
        applyStimulus(8'h3C, 1'b0, e0);
        repeat (20 * BIT) @(negedge clk);
        checkOutput("fe_ferr_count", ferr_edges.size(), 1);
        checkOutput("fe_ferr_edge", (ferr_edges.size() > 0) ? ferr_edges[0] : -1, e0 + STOP_SAMPLE);
        checkOutput("fe_valid_count", valid_edges.size(), 0);
        checkOutput("fe_data_held", data, 8'hFF);
        checkOutput("fe_break_rises", rise_edges.size(), 1);
        checkOutput("fe_busy", busy, 1'b0);
        RX = 1'b1;
        repeat (2 * BIT) @(negedge clk);

        // Asynchronous reset in the middle of data bit 4.
        clearLog();
        driveBit(1'b0);
        for (int i = 0; i < 4; i++) driveBit(aborted[i]);
        RX = aborted[4];
        repeat (BIT / 2) @(negedge clk);
        checkOutput("ar_busy_before", busy, 1'b1);
        #2;
        arst_n = 1'b0;
        #1;
        checkOutput("ar_busy", busy, 1'b0);
        checkOutput("ar_data", data, 8'h00);
        repeat (4) @(negedge clk);
        RX = 1'b1;
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        checkOutput("ar_valid_count", valid_edges.size(), 0);
        checkOutput("ar_ferr_count", ferr_edges.size(), 0);
        clearLog();
        applyStimulus(8'h5A, 1'b1, e0);
        repeat (BIT) @(negedge clk);
        checkOutput("ar_5a_valid_count", valid_edges.size(), 1);
        checkOutput("ar_5a_valid_edge", (valid_edges.size() > 0) ? valid_edges[0] : -1, e0 + STOP_SAMPLE);
        checkOutput("ar_5a_data", data, 8'h5A);

        // Synchronous clear pulsed during the stop bit, before its sample point.
        clearLog();
        e0 = edge_cnt + 1;
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) driveBit(i == 0 || i == 7);
        RX = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("sc_busy_before", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("sc_busy", busy, 1'b0);
        checkOutput("sc_data", data, 8'h00);
        repeat (2 * BIT) @(negedge clk);
        checkOutput("sc_valid_count", valid_edges.size(), 0);
        checkOutput("sc_ferr_count", ferr_edges.size(), 0);
        checkOutput("sc_rises", rise_edges.size(), 1);
        checkOutput("sc_rise_edge", (rise_edges.size() > 0) ? rise_edges[0] : -1, e0 + 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
